// File: rtl/alu_pkg.sv
// Shared definitions for the ALU flag logic: NZCV bit positions and condition codes.
package alu_pkg;

  // Bit positions inside a packed {N,Z,C,V} nibble.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

  // ARM condition codes as encoded in the B.cond instruction.
  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondHs = 4'h2,
    CondLo = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

endpackage

// File: rtl/zero_detect.sv
// Wide zero detector: OR-reduce fixed-size groups, then NOR the group results.
module zero_detect #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero
);

  localparam int unsigned GROUP   = 8;
  localparam int unsigned NGROUPS = (WIDTH + GROUP - 1) / GROUP;
  localparam int unsigned PADW    = NGROUPS * GROUP;

  logic [PADW-1:0]    padded;
  logic [NGROUPS-1:0] group_any;

  // Zero-extend to a whole number of groups so the last group needs no special case.
  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = data;
  end

  for (genvar g = 0; g < NGROUPS; g++) begin : g_group
    assign group_any[g] = |padded[g*GROUP +: GROUP];
  end

  assign zero = ~|group_any;

endmodule

// File: rtl/flag_unit.sv
// NZCV derivation, one-deep EX->MEM flag slot, architectural flag register, and
// forwarded branch resolution for B.cond / CBZ.
module flag_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_valid,
  input  logic             br_is_cbz,
  input  logic [3:0]       br_cond,
  output logic [3:0]       flags_arch,
  output logic             take_branch,
  output logic             flag_hazard
);

  logic  z_ex;
  nzcv_t nzcv_ex;
  logic  ex_write;
  logic  mem_valid;
  nzcv_t mem_flags;
  nzcv_t fwd_flags;
  logic  cond_true;
  cond_e cond;

  zero_detect #(
    .WIDTH (WIDTH)
  ) u_zero_detect (
    .data (alu_result),
    .zero (z_ex)
  );

  // EX-stage flag derivation; a flushed instruction neither writes nor forwards.
  always_comb begin
    nzcv_ex         = '0;
    nzcv_ex[FLAG_N] = alu_result[WIDTH-1];
    nzcv_ex[FLAG_Z] = z_ex;
    nzcv_ex[FLAG_C] = alu_cout;
    nzcv_ex[FLAG_V] = alu_ovf;
    ex_write        = ex_valid & ex_set_flags & ~flush;
  end

  // EX->MEM slot: advances whenever the pipe is not stalled; flush only gates new entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid <= 1'b0;
      mem_flags <= '0;
    end else if (!stall) begin
      mem_valid <= ex_write;
      mem_flags <= nzcv_ex;
    end
  end

  // Architectural flags take the slot contents on the same edge the slot reloads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_arch <= '0;
    end else if (mem_valid && !stall) begin
      flags_arch <= mem_flags;
    end
  end

  // Youngest producer wins: EX, then the pending slot, then committed flags.
  always_comb begin
    fwd_flags = flags_arch;
    if (ex_write) begin
      fwd_flags = nzcv_ex;
    end else if (mem_valid) begin
      fwd_flags = mem_flags;
    end
  end

  // Condition evaluation on the forwarded flags.
  always_comb begin
    cond      = cond_e'(br_cond);
    cond_true = 1'b0;
    unique case (cond)
      CondEq: cond_true = fwd_flags[FLAG_Z];
      CondNe: cond_true = ~fwd_flags[FLAG_Z];
      CondHs: cond_true = fwd_flags[FLAG_C];
      CondLo: cond_true = ~fwd_flags[FLAG_C];
      CondMi: cond_true = fwd_flags[FLAG_N];
      CondPl: cond_true = ~fwd_flags[FLAG_N];
      CondVs: cond_true = fwd_flags[FLAG_V];
      CondVc: cond_true = ~fwd_flags[FLAG_V];
      CondHi: cond_true = fwd_flags[FLAG_C] & ~fwd_flags[FLAG_Z];
      CondLs: cond_true = ~fwd_flags[FLAG_C] | fwd_flags[FLAG_Z];
      CondGe: cond_true = (fwd_flags[FLAG_N] == fwd_flags[FLAG_V]);
      CondLt: cond_true = (fwd_flags[FLAG_N] != fwd_flags[FLAG_V]);
      CondGt: cond_true = ~fwd_flags[FLAG_Z] & (fwd_flags[FLAG_N] == fwd_flags[FLAG_V]);
      CondLe: cond_true = fwd_flags[FLAG_Z] | (fwd_flags[FLAG_N] != fwd_flags[FLAG_V]);
      CondAl: cond_true = 1'b1;
      CondNv: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Branch decision; a stalled EX setter means its flags are not yet usable by B.cond.
  always_comb begin
    flag_hazard = br_valid & ~br_is_cbz & ex_write & stall;
    take_branch = 1'b0;
    if (br_valid) begin
      if (br_is_cbz) begin
        take_branch = z_ex;
      end else begin
        take_branch = cond_true & ~flag_hazard;
      end
    end
  end

endmodule
